fifo_deq_serializer: RTL and testbench
======================================

Name: fifo_deq_serializer

Overview:
- Consumer-side companion to the team's depth-2 FIFO: drives the FIFO's dequeue side (D_OUT / EMPTY_N / DEQ).
- Pops wide words and streams each as RATIO narrow beats on a valid/ready output with a last-beat marker.
- Sits between a wide-word FIFO and a narrow datapath or link transmitter.
- Supports back-to-back words with no bubble and an optional synchronous flush.

Parameters:
- IN_WIDTH, 32, width of FIFO word.
- OUT_WIDTH, 8, width of output beat. IN_WIDTH must be an integer multiple of OUT_WIDTH, with RATIO = IN_WIDTH/OUT_WIDTH >= 2. Any other value is a elaboration error.

Ports:
- CLK  in  1  clock. All state updates on posedge.
- RST  in  1  reset, synchronous, active-high.
- FIFO_D_OUT  in  IN_WIDTH  head word of upstream FIFO.
- FIFO_EMPTY_N  in  1  upstream FIFO has a word (1 = not empty).
- FIFO_DEQ  out  1  dequeue strobe to upstream FIFO; combinational.
- CLR  in  1  synchronous flush of the serializer.
- OUT_DATA  out  OUT_WIDTH  current beat.
- OUT_VALID  out  1  beat valid.
- OUT_READY  in  1  downstream accepts beat.
- OUT_LAST  out  1  current beat is the final beat of its word.
- BUSY  out  1  a word is held (equals OUT_VALID).

Behaviour:
- State: word_reg[IN_WIDTH], cnt[clog2(RATIO)], FSM state {EMPTY, SERIAL}.
- Reset (RST=1 at posedge):
  - state=EMPTY, cnt=0.
  - OUT_VALID=0, OUT_LAST=0, BUSY=0.
  - FIFO_DEQ=0 combinationally while RST=1.
  - word_reg is not reset; OUT_DATA is don't-care while OUT_VALID=0.
- Accept and load definitions:
  - accept = OUT_VALID & OUT_READY.
  - last_acc = accept & (cnt == RATIO-1).
  - FIFO_DEQ = FIFO_EMPTY_N & !CLR & !RST & (state==EMPTY | last_acc).
- EMPTY state:
  - OUT_VALID=0.
  - If FIFO_DEQ, next cycle: word_reg=FIFO_D_OUT, cnt=0, state=SERIAL.
  - Latency: a word dequeued in cycle t presents its first beat with OUT_VALID=1 in cycle t+1.
- SERIAL state:
  - OUT_VALID=1.
  - OUT_DATA = word_reg[cnt*OUT_WIDTH +: OUT_WIDTH]; beat 0 is the LSB slice.
  - OUT_LAST = (cnt == RATIO-1).
  - accept & !last_acc: cnt++.
  - last_acc & FIFO_EMPTY_N: reload word_reg from FIFO_D_OUT, cnt=0, stay SERIAL (no bubble).
  - last_acc & !FIFO_EMPTY_N: state=EMPTY.
  - !accept: all state held; OUT_DATA and OUT_LAST stable.
- CLR (synchronous, priority over everything except RST):
  - state=EMPTY, cnt=0 next cycle; FIFO_DEQ=0 in the CLR cycle.
  - A partially sent word is discarded; a beat accepted in the CLR cycle counts as delivered.
  - The upstream FIFO is not cleared by this block.
- Reset or CLR mid-word: the next word always starts at beat 0.
- Invariants:
  - FIFO_DEQ never asserts when FIFO_EMPTY_N=0.
  - At most one FIFO_DEQ per RATIO accepted beats.
  - cnt never exceeds RATIO-1.

Optional Feature:
- Macro SER_MSB_FIRST_EN.
- Defined: beat k is word_reg[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH], i.e. MSB slice first.
- Undefined (default): LSB slice first.
- All handshake, latency and OUT_LAST timing is identical in both builds.

Test Plan (IN_WIDTH=32, OUT_WIDTH=8):
- Reset: RST=1 for 2 cycles with FIFO_EMPTY_N=1 -> FIFO_DEQ=0 and OUT_VALID=0 throughout; FIFO_DEQ=1 in the first cycle after RST drops.
- Single word 0xA1B2C3D4, OUT_READY=1 -> exactly one FIFO_DEQ pulse; beats D4,C3,B2,A1 on 4 consecutive cycles; OUT_LAST only on A1; then OUT_VALID=0.
- Back-to-back words 0x03020100 then 0x07060504, FIFO never empty, OUT_READY=1 -> 8 consecutive beats 00..07 with no bubble; second FIFO_DEQ coincides with the beat-03 accept cycle.
- Backpressure: same word with OUT_READY pattern 1,0,0,1,0,1,1 -> OUT_DATA/OUT_LAST stable during stalls; sequence D4,C3,B2,A1 with no drop or duplicate; one FIFO_DEQ.
- CLR asserted in the cycle after beat C3 is accepted (FIFO non-empty) -> FIFO_DEQ=0 that cycle; OUT_VALID=0 next cycle; next word starts at beat 0.
- SER_MSB_FIRST_EN defined, word 0xA1B2C3D4 -> beats A1,B2,C3,D4; OUT_LAST on D4. Repeat with RST mid-word -> restart at beat 0.

Source files
------------

// File: rtl/fifo_deq_serializer.sv
// fifo_deq_serializer: pops wide words from an upstream FIFO and streams
// each one as RATIO = IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready port.
// Optional build macro SER_MSB_FIRST_EN: send the most-significant slice
// first (default is least-significant slice first).
module fifo_deq_serializer #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [IN_WIDTH-1:0]  FIFO_D_OUT,
    input  logic                 FIFO_EMPTY_N,
    output logic                 FIFO_DEQ,
    input  logic                 CLR,
    output logic [OUT_WIDTH-1:0] OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 OUT_LAST,
    output logic                 BUSY
);

    localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    // Reject widths that cannot be split into at least two equal beats
    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_param_check
        $error("fifo_deq_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end

    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_SERIAL = 1'b1
    } state_t;

    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [RATIO-1:0][OUT_WIDTH-1:0]   word_q, word_d;
    logic [CNT_W-1:0]                  slice_idx;
    logic                              accept;
    logic                              last_acc;

    // State and beat counter register; word holding register is not reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Word register loads only on a dequeue; contents are don't-care otherwise
    always_ff @(posedge CLK) begin
        word_q <= word_d;
    end

    // Next-state, counter, load and dequeue decisions
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        accept   = (state_q == S_SERIAL) && OUT_READY;
        last_acc = accept && (cnt_q == CNT_LAST);
        FIFO_DEQ = FIFO_EMPTY_N && !CLR && !RST
                   && ((state_q == S_EMPTY) || last_acc);

        if (CLR) begin
            // Flush drops any partially sent word; upstream FIFO is untouched
            state_d = S_EMPTY;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (FIFO_DEQ) begin
                        word_d  = FIFO_D_OUT;
                        cnt_d   = '0;
                        state_d = S_SERIAL;
                    end
                end
                S_SERIAL: begin
                    if (last_acc) begin
                        cnt_d = '0;
                        if (FIFO_DEQ) begin
                            // Reload on the last beat so words flow without a bubble
                            word_d = FIFO_D_OUT;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end else if (accept) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Beat order selection
`ifdef SER_MSB_FIRST_EN
    assign slice_idx = CNT_LAST - cnt_q;
`else
    assign slice_idx = cnt_q;
`endif

    // Output view of the held word
    assign OUT_VALID = (state_q == S_SERIAL);
    assign BUSY      = OUT_VALID;
    assign OUT_LAST  = OUT_VALID && (cnt_q == CNT_LAST);
    assign OUT_DATA  = word_q[slice_idx];

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// Scoreboard bench for fifo_deq_serializer (IN_WIDTH=32, OUT_WIDTH=8).
// Upstream FIFO and expected beat stream are modelled with queues.
module tb_fifo_deq_serializer;

    localparam int IW = 32;
    localparam int OW = 8;
    localparam int R  = IW / OW;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    logic          CLK;
    logic          RST;
    logic [IW-1:0] FIFO_D_OUT;
    logic          FIFO_EMPTY_N;
    logic          FIFO_DEQ;
    logic          CLR;
    logic [OW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          OUT_LAST;
    logic          BUSY;

    logic [IW-1:0] fifo_q[$];   // upstream FIFO contents
    beat_t         beats[$];    // beats still owed by the DUT
    int            n_cmp = 0;
    int            n_bad = 0;

    fifo_deq_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .FIFO_D_OUT  (FIFO_D_OUT),
        .FIFO_EMPTY_N(FIFO_EMPTY_N),
        .FIFO_DEQ    (FIFO_DEQ),
        .CLR         (CLR),
        .OUT_DATA    (OUT_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_LAST    (OUT_LAST),
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand a word into its beat sequence in transmission order
    task automatic push_beats(input logic [IW-1:0] w);
        beat_t b;
        for (int k = 0; k < R; k++) begin
`ifdef SER_MSB_FIRST_EN
            b.data = OW'(w >> ((R - 1 - k) * OW));
`else
            b.data = OW'(w >> (k * OW));
`endif
            b.last = (k == R - 1);
            beats.push_back(b);
        end
    endtask

    // Monitor: mid-cycle check of the DUT against the beat scoreboard
    always @(negedge CLK) begin
        logic exp_valid;
        logic acc;
        logic exp_deq;
        exp_valid = (beats.size() != 0);
        acc       = exp_valid && OUT_READY;
        exp_deq   = FIFO_EMPTY_N && !CLR && !RST
                    && ((beats.size() == 0) || (acc && beats.size() == 1));
        chk("out_valid", 32'(OUT_VALID), 32'(exp_valid));
        chk("busy",      32'(BUSY),      32'(exp_valid));
        chk("fifo_deq",  32'(FIFO_DEQ),  32'(exp_deq));
        if (exp_valid) begin
            chk("out_data", 32'(OUT_DATA), 32'(beats[0].data));
            chk("out_last", 32'(OUT_LAST), 32'(beats[0].last));
        end
        if (acc) void'(beats.pop_front());
        if (RST || CLR) beats.delete();
        if (FIFO_DEQ) begin
            if (fifo_q.size() == 0) begin
                chk("deq_on_empty", 32'(1), 32'(0));
            end else begin
                push_beats(fifo_q.pop_front());
            end
        end
    end

    // Present the head of the upstream FIFO model
    task automatic refresh();
        FIFO_EMPTY_N = (fifo_q.size() != 0);
        FIFO_D_OUT   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_word(input logic [IW-1:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    // Drive one cycle of control inputs, then move just past the next edge
    task automatic step(input logic rdy, input logic clr, input logic rst);
        OUT_READY = rdy;
        CLR       = clr;
        RST       = rst;
        @(posedge CLK);
        #1;
        refresh();
    endtask

    initial begin
        logic [6:0] bp_pat;
        RST = 1'b1; CLR = 1'b0; OUT_READY = 1'b0;
        FIFO_EMPTY_N = 1'b0; FIFO_D_OUT = '0;

        // Reset held two cycles with a word waiting, then single word
        push_word(32'hA1B2C3D4);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);

        // Back-to-back words, FIFO never empty
        push_word(32'h03020100);
        push_word(32'h07060504);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0);

        // Backpressure pattern 1,0,0,1,0,1,1 after the load cycle
        push_word(32'hA1B2C3D4);
        step(1'b0, 1'b0, 1'b0);
        bp_pat = 7'b1101001;
        for (int i = 0; i < 7; i++) step(bp_pat[i], 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);

        // Flush after two beats with the FIFO non-empty
        push_word(32'hA1B2C3D4);
        push_word(32'h11223344);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);

        // Reset in the middle of a word
        push_word(32'hA1B2C3D4);
        push_word(32'h55667788);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (fifo_q.size() < 2 && $urandom_range(2, 0) != 0) push_word($urandom);
            step(1'($urandom_range(3, 0) != 0),
                 1'($urandom_range(39, 0) == 0),
                 1'($urandom_range(79, 0) == 0));
        end

        // Drain and confirm nothing is owed
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);
        chk("drained_beats", 32'(beats.size()), 32'(0));
        chk("drained_fifo",  32'(fifo_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
